// File: rtl/bcd_scan_ctrl_pkg.sv
// Shared types and constants for the BCD digit scan controller.
// Imported by bcd_scan_ctrl and scan_timer.
package bcd_scan_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      DWELL = 2'd1,
      GUARD = 2'd2
   } scan_state_t;

   localparam logic [3:0] BCD_BLANK = 4'hF;
   // Wide enough for the largest supported digit count; callers slice it.
   localparam logic [7:0] DIGIT_OFF = 8'hFF;

endpackage

// File: rtl/bcd_scan_ctrl_scan_timer.sv
// Dwell/guard interval counter for bcd_scan_ctrl.
// Counts 0..term and raises tc on the terminal value, then restarts at 0.
module scan_timer
   import bcd_scan_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [CNT_W-1:0] term,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   assign tc = (count == term);

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr || tc) count <= '0;
      else                  count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Scans NUM_DIGITS stored BCD digits onto one shared 14-segment decoder with blanking guards.
// Optional build macro BCD_SCAN_LZB_EN enables leading-zero blanking.
module bcd_scan_ctrl
   import bcd_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD_CYC   = 2,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  wr_en,
   input  logic [2:0]            wr_addr,
   input  logic [3:0]            wr_data,
   output logic [3:0]            bcd_out,
   output logic [NUM_DIGITS-1:0] digit_sel,
   output logic [2:0]            scan_idx,
   output logic                  frame_tick
);

   localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [3:0]        NUM_W    = 4'(NUM_DIGITS);

   scan_state_t             state, state_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [3:0]              digits [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   lzb;
   logic [NUM_DIGITS-1:0]   sel_nxt;
   logic [3:0]              bcd_nxt;
   logic                    tick_nxt;
   logic                    tc;
   logic [CNT_W-1:0]        term;

   assign term     = (state == DWELL) ? CNT_W'(REFRESH_DIV - 1) : CNT_W'(GUARD_CYC - 1);
   assign scan_idx = 3'(idx);

   scan_timer #(.CNT_W(CNT_W)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (!en || (state == OFF)),
      .term (term),
      .tc   (tc)
   );

   // A digit is blanked when it and every higher digit are zero; digit 0 always shows.
   always_comb begin
      lzb = '0;
`ifdef BCD_SCAN_LZB_EN
      for (int i = NUM_DIGITS - 1, logic zero_run = 1'b1; i > 0; i--) begin
         zero_run = zero_run && (digits[i] == 4'd0);
         lzb[i]   = zero_run;
      end
`endif
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      tick_nxt  = 1'b0;
      if (!en) begin
         state_nxt = OFF;
         idx_nxt   = '0;
      end else begin
         unique case (state)
            OFF: begin
               state_nxt = DWELL;
               idx_nxt   = '0;
            end
            DWELL: if (tc) state_nxt = GUARD;
            GUARD: if (tc) begin
               state_nxt = DWELL;
               if (idx == LAST_IDX) begin
                  idx_nxt  = '0;
                  tick_nxt = 1'b1;
               end else begin
                  idx_nxt  = idx + IDX_W'(1);
               end
            end
            default: state_nxt = OFF;
         endcase
      end

      sel_nxt = DIGIT_OFF[NUM_DIGITS-1:0];
      bcd_nxt = BCD_BLANK;
      if (state_nxt == DWELL) begin
         sel_nxt[idx_nxt] = 1'b0;
         bcd_nxt          = lzb[idx_nxt] ? BCD_BLANK : digits[idx_nxt];
      end
   end

   // NOTE: the digit register file is reset because the display must come up showing zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= OFF;
         idx        <= '0;
         bcd_out    <= BCD_BLANK;
         digit_sel  <= DIGIT_OFF[NUM_DIGITS-1:0];
         frame_tick <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'd0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         bcd_out    <= bcd_nxt;
         digit_sel  <= sel_nxt;
         frame_tick <= tick_nxt;
         if (wr_en && ({1'b0, wr_addr} < NUM_W)) digits[wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl (4 digits, dwell 4, guard 1): vector table,
// directed corner sequences and random stimulus against a frame-position reference model.
module tb_bcd_scan_ctrl;

   localparam int RDIV    = 4;
   localparam int GCYC    = 1;
   localparam int SLOT    = RDIV + GCYC;
   localparam int FRAME   = 4 * SLOT;

   logic       clk = 1'b0;
   logic       rst, en, wr_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic [3:0] bcd_out;
   logic [3:0] digit_sel;
   logic [2:0] scan_idx;
   logic       frame_tick;

   int total = 0;
   int bad   = 0;

   // Reference model: frame position since scanning started.
   logic [3:0] m_dig [4];
   bit         m_active = 1'b0;
   int         m_cyc    = 0;
   int         m_p      = -1;
   int         m_d      = 0;
   bit         m_lit    = 1'b0;

   typedef struct {
      logic       en;
      logic       we;
      logic [2:0] addr;
      logic [3:0] data;
      logic [3:0] bcd;
      logic [3:0] sel;
      logic [2:0] idx;
      logic       tick;
   } vec_t;

   vec_t tbl [25];

   bcd_scan_ctrl #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (RDIV),
      .GUARD_CYC   (GCYC),
      .CNT_W       (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .bcd_out    (bcd_out),
      .digit_sel  (digit_sel),
      .scan_idx   (scan_idx),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_blank(input int d);
`ifdef BCD_SCAN_LZB_EN
      if (d == 0) return 1'b0;
      for (int j = d; j < 4; j++) if (m_dig[j] != 4'd0) return 1'b0;
      return 1'b1;
`else
      return (d < 0);
`endif
   endfunction

   // Drive one clock of inputs, advance the model, compare every output.
   task automatic step(input logic r, input logic e, input logic we,
                       input logic [2:0] a, input logic [3:0] d);
      logic [3:0] eb, es;
      logic [2:0] ei;
      logic       et;
      rst = r; en = e; wr_en = we; wr_addr = a; wr_data = d;
      @(posedge clk);
      #1;
      eb = 4'hF; es = 4'hF; ei = 3'd0; et = 1'b0;
      m_lit = 1'b0; m_p = -1;
      if (r) begin
         m_active = 1'b0;
         for (int j = 0; j < 4; j++) m_dig[j] = 4'd0;
      end else begin
         if (!e)             m_active = 1'b0;
         else if (!m_active) begin m_active = 1'b1; m_cyc = 0; end
         else                m_cyc++;
         if (m_active) begin
            m_p   = m_cyc % FRAME;
            m_d   = m_p / SLOT;
            m_lit = (m_p % SLOT) < RDIV;
            ei    = 3'(m_d);
            et    = (m_p == 0) && (m_cyc > 0);
            if (m_lit) begin
               es = ~(4'b0001 << m_d);
               eb = m_blank(m_d) ? 4'hF : m_dig[m_d];
            end
         end
         if (we && a < 3'd4) m_dig[a] = d;
      end
      check("model_bcd",  32'(bcd_out),    32'(eb));
      check("model_sel",  32'(digit_sel),  32'(es));
      check("model_idx",  32'(scan_idx),   32'(ei));
      check("model_tick", 32'(frame_tick), 32'(et));
   endtask

   function automatic vec_t mk(input logic e, input logic we, input logic [2:0] a,
                               input logic [3:0] d, input logic [3:0] b, input logic [3:0] s,
                               input logic [2:0] i, input logic t);
      vec_t v;
      v.en = e; v.we = we; v.addr = a; v.data = d;
      v.bcd = b; v.sel = s; v.idx = i; v.tick = t;
      return v;
   endfunction

   logic [3:0] exp_oor [4];
   logic [3:0] exp_lzb [4];

   initial begin
      // Writes while dark, then one full frame plus the wrap edge.
      tbl[0]  = mk(0,1,3'd0,4'd1, 4'hF,4'b1111,3'd0,0);
      tbl[1]  = mk(0,1,3'd1,4'd2, 4'hF,4'b1111,3'd0,0);
      tbl[2]  = mk(0,1,3'd2,4'd3, 4'hF,4'b1111,3'd0,0);
      tbl[3]  = mk(0,1,3'd3,4'd4, 4'hF,4'b1111,3'd0,0);
      tbl[4]  = mk(1,0,3'd0,4'd0, 4'd1,4'b1110,3'd0,0);
      tbl[5]  = mk(1,0,3'd0,4'd0, 4'd1,4'b1110,3'd0,0);
      tbl[6]  = mk(1,0,3'd0,4'd0, 4'd1,4'b1110,3'd0,0);
      tbl[7]  = mk(1,0,3'd0,4'd0, 4'd1,4'b1110,3'd0,0);
      tbl[8]  = mk(1,0,3'd0,4'd0, 4'hF,4'b1111,3'd0,0);
      tbl[9]  = mk(1,0,3'd0,4'd0, 4'd2,4'b1101,3'd1,0);
      tbl[10] = mk(1,0,3'd0,4'd0, 4'd2,4'b1101,3'd1,0);
      tbl[11] = mk(1,0,3'd0,4'd0, 4'd2,4'b1101,3'd1,0);
      tbl[12] = mk(1,0,3'd0,4'd0, 4'd2,4'b1101,3'd1,0);
      tbl[13] = mk(1,0,3'd0,4'd0, 4'hF,4'b1111,3'd1,0);
      tbl[14] = mk(1,0,3'd0,4'd0, 4'd3,4'b1011,3'd2,0);
      tbl[15] = mk(1,0,3'd0,4'd0, 4'd3,4'b1011,3'd2,0);
      tbl[16] = mk(1,0,3'd0,4'd0, 4'd3,4'b1011,3'd2,0);
      tbl[17] = mk(1,0,3'd0,4'd0, 4'd3,4'b1011,3'd2,0);
      tbl[18] = mk(1,0,3'd0,4'd0, 4'hF,4'b1111,3'd2,0);
      tbl[19] = mk(1,0,3'd0,4'd0, 4'd4,4'b0111,3'd3,0);
      tbl[20] = mk(1,0,3'd0,4'd0, 4'd4,4'b0111,3'd3,0);
      tbl[21] = mk(1,0,3'd0,4'd0, 4'd4,4'b0111,3'd3,0);
      tbl[22] = mk(1,0,3'd0,4'd0, 4'd4,4'b0111,3'd3,0);
      tbl[23] = mk(1,0,3'd0,4'd0, 4'hF,4'b1111,3'd3,0);
      tbl[24] = mk(1,0,3'd0,4'd0, 4'd1,4'b1110,3'd0,1);

      exp_oor = '{4'd1, 4'd2, 4'd9, 4'd4};
`ifdef BCD_SCAN_LZB_EN
      exp_lzb = '{4'd0, 4'd4, 4'hF, 4'hF};
`else
      exp_lzb = '{4'd0, 4'd4, 4'd0, 4'd0};
`endif

      // Reset, including a write that must be ignored.
      step(1, 0, 1, 3'd0, 4'd7);
      step(1, 0, 0, 3'd0, 4'd0);
      check("rst_bcd",  32'(bcd_out),    32'hF);
      check("rst_sel",  32'(digit_sel),  32'hF);
      check("rst_tick", 32'(frame_tick), 32'h0);

      foreach (tbl[i]) begin
         step(1'b0, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].data);
         check($sformatf("tbl%0d_bcd", i),  32'(bcd_out),    32'(tbl[i].bcd));
         check($sformatf("tbl%0d_sel", i),  32'(digit_sel),  32'(tbl[i].sel));
         check($sformatf("tbl%0d_idx", i),  32'(scan_idx),   32'(tbl[i].idx));
         check($sformatf("tbl%0d_tick", i), 32'(frame_tick), 32'(tbl[i].tick));
      end

      // Live write into digit 2 while it is lit.
      for (int i = 0; i < 2 * FRAME && m_p != 10; i++) step(0, 1, 0, 3'd0, 4'd0);
      check("reach_d2", 32'(digit_sel), 32'b1011);
      step(0, 1, 1, 3'd2, 4'd9);
      check("wr_edge_old", 32'(bcd_out), 32'd3);
      step(0, 1, 0, 3'd0, 4'd0);
      check("wr_next_new", 32'(bcd_out), 32'd9);

      // Drop enable mid-dwell of digit 1, then restart.
      for (int i = 0; i < 2 * FRAME && m_p != 6; i++) step(0, 1, 0, 3'd0, 4'd0);
      check("reach_d1", 32'(digit_sel), 32'b1101);
      step(0, 0, 0, 3'd0, 4'd0);
      check("off_sel", 32'(digit_sel), 32'hF);
      check("off_bcd", 32'(bcd_out),   32'hF);
      check("off_idx", 32'(scan_idx),  32'h0);
      step(0, 1, 0, 3'd0, 4'd0);
      check("restart_sel", 32'(digit_sel), 32'b1110);
      check("restart_bcd", 32'(bcd_out),   32'd1);

      // Out-of-range write leaves every digit untouched for a whole frame.
      step(0, 1, 1, 3'd5, 4'd7);
      for (int i = 0; i < FRAME; i++) begin
         step(0, 1, 0, 3'd0, 4'd0);
         if (m_lit) check("oor_hold", 32'(bcd_out), 32'(exp_oor[m_d]));
      end

      // Reset with a concurrent write clears digits; digit 0 then shows 0.
      step(1, 0, 1, 3'd0, 4'd5);
      step(0, 0, 1, 3'd1, 4'd4);
      step(0, 1, 0, 3'd0, 4'd0);
      check("rst_wr_bcd", 32'(bcd_out),   32'd0);
      check("rst_wr_sel", 32'(digit_sel), 32'b1110);
      for (int i = 0; i < FRAME; i++) begin
         step(0, 1, 0, 3'd0, 4'd0);
         if (m_lit) check("lzb", 32'(bcd_out), 32'(exp_lzb[m_d]));
      end

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         step(($urandom % 200) == 0, ($urandom % 40) != 0, $urandom % 2,
              3'($urandom % 8), 4'($urandom % 16));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
